// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider for the Z-low/Z-high bus sources.
// Restoring shift-subtract on operand magnitudes, one quotient bit per
// clock, then a sign-fix cycle and a one-cycle done pulse.
//
// Handshake: start is sampled only in IDLE; the operands are captured on
// that same edge. While busy=1 further start pulses are ignored and
// nothing is queued. done=1 for exactly one cycle (the DONE state, where
// busy is also 1). Zlow/Zhigh/div_by_zero are stable from that cycle
// until the next operation writes them.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] Zlow,
    output logic [WIDTH-1:0] Zhigh,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_zlow;
    logic [WIDTH-1:0] r_zhigh;
    logic             r_dbz;

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic             w_dsr_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Magnitudes as unsigned: the most negative value maps to 2^(WIDTH-1).
    assign w_dvd_abs  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_dsr_abs  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_dsr_zero = (divisor == '0);

    // Partial remainder shifted left with the next dividend bit, and the
    // trial subtraction one bit wider so its MSB acts as the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dsr};

    // State register.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_dsr_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (r_count == LAST_COUNT) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_count  <= '0;
            r_zlow   <= '0;
            r_zhigh  <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dsr_zero) begin
                            r_zlow  <= '1;
                            r_zhigh <= dividend;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_rem    <= '0;
                            r_quo    <= w_dvd_abs;
                            r_dsr    <= w_dsr_abs;
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                            r_count  <= '0;
                        end
                    end
                end
                S_ITER: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_zlow  <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
                    r_zhigh <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                    r_dbz   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign Zlow        = r_zlow;
    assign Zhigh       = r_zhigh;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table of signed divisions plus directed
// sequences for start-while-busy, mid-operation reset and back-to-back.
module tb_div_unit;

    logic        clk;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] Zlow;
    logic [31:0] Zhigh;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .Zlow        (Zlow),
        .Zhigh       (Zhigh),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for done, returning cycles counted after the sample
    // that follows the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // One full division: accept, latency, results, busy/done shape.
    task automatic run_div(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input int elat);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(elat));
        chk($sformatf("v%0d zlow", idx), Zlow, eq);
        chk($sformatf("v%0d zhigh", idx), Zhigh, er);
        chk($sformatf("v%0d dbz", idx), {31'd0, div_by_zero}, {31'd0, edbz});
        chk($sformatf("v%0d busy_in_done", idx), {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d busy_after", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d done_after", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d zlow_hold", idx), Zlow, eq);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] seen_q;
        logic [31:0] seen_r;

        vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
        vecs[4]  = '{32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 33};
        vecs[5]  = '{32'd123,      32'd0,        32'hFFFFFFFF, 32'd123,      1'b1, 0};
        vecs[6]  = '{32'd10,       32'd3,        32'd3,        32'd1,        1'b0, 33};
        vecs[7]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
        vecs[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 33};
        vecs[9]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 33};
        vecs[10] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};
        vecs[11] = '{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 0};
        vecs[12] = '{32'd1,        32'd1,        32'd1,        32'd0,        1'b0, 33};
        vecs[13] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 33};

        clear    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst zlow", Zlow, 32'd0);
        chk("rst zhigh", Zhigh, 32'd0);
        chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_div(i, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        // start pulsed while busy is ignored: 50/5 then 100/7 at E+5.
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses = 0;
        seen_q = '0;
        seen_r = '0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                seen_q = Zlow;
                seen_r = Zhigh;
            end
        end
        chk("ign pulses", 32'(pulses), 32'd1);
        chk("ign zlow", seen_q, 32'd10);
        chk("ign zhigh", seen_r, 32'd0);

        // Reset at E+10 of 1000/3 aborts with nothing exposed.
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort zlow", Zlow, 32'd0);
        chk("abort zhigh", Zhigh, 32'd0);
        @(negedge clk);
        clear = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk("abort no_done", 32'(pulses), 32'd0);
        run_div(100, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

        // start held high: re-accepted on the first IDLE edge (E+35).
        @(negedge clk);
        start = 1'b1; dividend = 32'd7; divisor = 32'd2;
        @(posedge clk);
        #1;
        wait_done(n);
        chk("b2b lat1", 32'(n), 32'd33);
        dividend = 32'd20; divisor = 32'd6;
        @(posedge clk);
        #1;
        chk("b2b idle_gap", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(n);
        chk("b2b lat2", 32'(n), 32'd33);
        chk("b2b zlow", Zlow, 32'd3);
        chk("b2b zhigh", Zhigh, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
